// File: rtl/game_counter_tally.sv
// Multimode up/down game counter with win/loss tallies feeding the winner-decision stage.
// Latency: count, tallies and flags are registered; each updates on the edge after its inputs.
// No backpressure: one step per enabled cycle; the block freezes in OVER until restart or reset.
module game_counter_tally #(
    parameter int WIDTH   = 4,
    parameter int SCORE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic               load,
    input  logic [WIDTH-1:0]   init_val,
    input  logic               restart,
    output logic [WIDTH-1:0]   count,
    output logic [SCORE_W-1:0] winner_cnt,
    output logic [SCORE_W-1:0] loser_cnt,
    output logic               winner_flag,
    output logic               loser_flag
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        OVER = 1'b1
    } state_t;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [WIDTH-1:0]   ALL_ONES  = '1;
    localparam logic [WIDTH-1:0]   ZERO      = '0;

    state_t             state, state_next;
    logic [WIDTH-1:0]   count_q, count_next;
    logic [SCORE_W-1:0] win_q, win_next;
    logic [SCORE_W-1:0] lose_q, lose_next;
    logic               wflag_q, wflag_next;
    logic               lflag_q, lflag_next;
    logic [WIDTH-1:0]   delta;
    logic [WIDTH-1:0]   step_val;

    // Step size as a WIDTH-bit two's-complement value, so the add wraps modulo 2^WIDTH.
    always_comb begin
        delta = '0;
        unique case (mode)
            2'b00:   delta = WIDTH'(1);
            2'b01:   delta = WIDTH'(2);
            2'b10:   delta = ALL_ONES;
            default: delta = {{(WIDTH-1){1'b1}}, 1'b0};
        endcase
        step_val = count_q + delta;
    end

    // Next state: restart beats load beats step; OVER holds everything except on restart.
    always_comb begin
        state_next = state;
        count_next = count_q;
        win_next   = win_q;
        lose_next  = lose_q;
        wflag_next = wflag_q;
        lflag_next = lflag_q;
        if (restart) begin
            state_next = RUN;
            count_next = init_val;
            win_next   = '0;
            lose_next  = '0;
            wflag_next = 1'b0;
            lflag_next = 1'b0;
        end else if (state == RUN) begin
            if (load) begin
                count_next = init_val;
            end else if (en) begin
                count_next = step_val;
                // Tallies are below SCORE_MAX while in RUN, so the increment cannot wrap.
                if (step_val == ALL_ONES) begin
                    win_next = win_q + 1'b1;
                    if (win_next == SCORE_MAX) begin
                        wflag_next = 1'b1;
                        state_next = OVER;
                    end
                end else if (step_val == ZERO) begin
                    lose_next = lose_q + 1'b1;
                    if (lose_next == SCORE_MAX) begin
                        lflag_next = 1'b1;
                        state_next = OVER;
                    end
                end
            end
        end
    end

    // State and datapath registers; reset clears everything without scoring.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            count_q <= '0;
            win_q   <= '0;
            lose_q  <= '0;
            wflag_q <= 1'b0;
            lflag_q <= 1'b0;
        end else begin
            state   <= state_next;
            count_q <= count_next;
            win_q   <= win_next;
            lose_q  <= lose_next;
            wflag_q <= wflag_next;
            lflag_q <= lflag_next;
        end
    end

    assign count       = count_q;
    assign winner_cnt  = win_q;
    assign loser_cnt   = lose_q;
    assign winner_flag = wflag_q;
    assign loser_flag  = lflag_q;

endmodule

// File: tb/tb_game_counter_tally.sv
// Self-checking bench for game_counter_tally against a behavioural game model.
// Latency: model advances on each rising edge; outputs sampled 1ns after it.
// No backpressure involved; all waits are bounded by cycle budgets.
module tb_game_counter_tally;

    localparam int WIDTH   = 4;
    localparam int SCORE_W = 4;
    localparam int M       = 1 << WIDTH;
    localparam int SMAX    = (1 << SCORE_W) - 1;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic [1:0]         mode;
    logic               load;
    logic [WIDTH-1:0]   init_val;
    logic               restart;
    logic [WIDTH-1:0]   count;
    logic [SCORE_W-1:0] winner_cnt;
    logic [SCORE_W-1:0] loser_cnt;
    logic               winner_flag;
    logic               loser_flag;

    int tests  = 0;
    int errors = 0;

    // Behavioural game state
    int  md_count;
    int  md_win;
    int  md_lose;
    bit  md_over;

    game_counter_tally #(.WIDTH(WIDTH), .SCORE_W(SCORE_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .mode        (mode),
        .load        (load),
        .init_val    (init_val),
        .restart     (restart),
        .count       (count),
        .winner_cnt  (winner_cnt),
        .loser_cnt   (loser_cnt),
        .winner_flag (winner_flag),
        .loser_flag  (loser_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},  int'(count),       md_count);
        check({tag, ".win"},    int'(winner_cnt),  md_win);
        check({tag, ".lose"},   int'(loser_cnt),   md_lose);
        check({tag, ".wflag"},  int'(winner_flag), int'(md_win == SMAX));
        check({tag, ".lflag"},  int'(loser_flag),  int'(md_lose == SMAX));
    endtask

    // Game rules applied to one clock edge.
    task automatic model_edge(input bit e, input int md, input bit ld, input int iv, input bit rs);
        int d;
        if (rs) begin
            md_count = iv; md_win = 0; md_lose = 0; md_over = 0;
        end else if (!md_over) begin
            if (ld) begin
                md_count = iv;
            end else if (e) begin
                d = (md == 0) ? 1 : (md == 1) ? 2 : (md == 2) ? -1 : -2;
                md_count = ((md_count + d) % M + M) % M;
                if (md_count == M - 1) md_win++;
                else if (md_count == 0) md_lose++;
                if (md_win == SMAX || md_lose == SMAX) md_over = 1;
            end
        end
    endtask

    // Drive one cycle of inputs, advance DUT and model, then compare.
    task automatic cyc(input string tag, input bit e, input int md, input bit ld,
                       input int iv, input bit rs);
        en = e; mode = 2'(md); load = ld; init_val = WIDTH'(iv); restart = rs;
        @(posedge clk);
        model_edge(e, md, ld, iv, rs);
        #1;
        check_all(tag);
    endtask

    initial begin
        en = 0; mode = 0; load = 0; init_val = 0; restart = 0;
        rst_n = 1'b0;
        md_count = 0; md_win = 0; md_lose = 0; md_over = 0;
        #12;
        check_all("reset");
        rst_n = 1'b1;

        // 1: build count=9, winner_cnt=3, then reset between edges
        for (int i = 0; i < 3; i++) begin
            cyc("t1.ld", 0, 0, 1, 14, 0);
            cyc("t1.st", 1, 0, 0, 0, 0);
        end
        cyc("t1.ld9", 0, 0, 1, 9, 0);
        check("t1.pre_count", int'(count), 9);
        check("t1.pre_win", int'(winner_cnt), 3);
        @(negedge clk);
        rst_n = 1'b0;
        md_count = 0; md_win = 0; md_lose = 0; md_over = 0;
        #1;
        check_all("t1.async");
        @(negedge clk);
        rst_n = 1'b1;

        // 2: count up through a full wrap from 0
        cyc("t2.ld", 0, 0, 1, 0, 0);
        for (int i = 0; i < 16; i++) cyc("t2.up", 1, 0, 0, 0, 0);
        check("t2.win", int'(winner_cnt), 1);
        check("t2.lose", int'(loser_cnt), 1);

        // 3: -2 from 5 wraps past zero to 15 without landing on 0
        cyc("t3.ld", 0, 0, 1, 5, 0);
        for (int i = 0; i < 4; i++) cyc("t3.dn2", 1, 3, 0, 0, 0);
        check("t3.count", int'(count), 13);
        check("t3.win", int'(winner_cnt), 2);

        // 4: fresh game from 14 counting up until the 15th win
        cyc("t4.rs", 0, 0, 0, 0, 1);
        cyc("t4.ld", 0, 0, 1, 14, 0);
        for (int i = 0; i < 400 && !md_over; i++) cyc("t4.run", 1, 0, 0, 0, 0);
        check("t4.over_reached", int'(md_over), 1);
        check("t4.win", int'(winner_cnt), 15);
        check("t4.lose", int'(loser_cnt), 14);
        check("t4.wflag", int'(winner_flag), 1);
        for (int i = 0; i < 4; i++) cyc("t4.hold", 1, i, i[0], 3, 0);
        check("t4.count_hold", int'(count), 15);

        // 5: restart out of OVER, then resume counting
        cyc("t5.rs", 1, 0, 1, 7, 1);
        check("t5.count", int'(count), 7);
        check("t5.wflag", int'(winner_flag), 0);
        cyc("t5.run", 1, 0, 0, 0, 0);
        check("t5.resume", int'(count), 8);

        // 6: load to all-ones does not score; restart dominates load
        cyc("t6.ld15", 1, 1, 1, 15, 0);
        check("t6.win", int'(winner_cnt), 0);
        cyc("t6.up", 1, 0, 0, 0, 0);
        cyc("t6.rsld", 1, 0, 1, 2, 1);
        check("t6.lose", int'(loser_cnt), 0);

        // Randomized play
        for (int i = 0; i < 3000; i++) begin
            cyc("rand",
                ($urandom_range(3) != 0),
                int'($urandom_range(3)),
                ($urandom_range(15) == 0),
                int'($urandom_range(M - 1)),
                ($urandom_range(199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    // Global watchdog so the bench always ends on its own.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
